seg7_scan_ctrl: RTL and testbench



---
 rtl/seg7_scan_ctrl_if.sv | 12 +
 rtl/seg7_scan_ctrl.sv | 117 +++++++++++
 tb/tb_seg7_scan_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_ctrl_if.sv
// Display-side bundle of the 4-digit scan controller: digit data in, decoder nibble,
// anode selects and frame marker out.
interface seg7_scan_ctrl_if;
    logic [15:0] value;
    logic [3:0]  digit_en;
    logic [3:0]  nibble;
    logic [3:0]  an_n;
    logic        frame_start;

    modport master (output value, digit_en, input nibble, an_n, frame_start);
    modport slave  (input value, digit_en, output nibble, an_n, frame_start);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit common-anode 7-segment display.
// Optional leading-zero blanking is built when SEG7_LZB_EN is defined.
module seg7_scan_ctrl #(
    parameter int SCAN_DIV = 50000
) (
    input  logic          clk,
    input  logic          reset,
    seg7_scan_ctrl_if.slave bus
);
    localparam int CW = $clog2(SCAN_DIV + 1);
    localparam logic [CW-1:0] TICK = CW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {LOAD, SCAN, GUARD} state_t;

    state_t          state_reg, state_next;
    logic [1:0]      idx_reg, idx_next;
    logic [CW-1:0]   presc_reg, presc_next;
    logic [15:0]     val_sh_reg, val_sh_next;
    logic [3:0]      en_sh_reg, en_sh_next;
    logic [3:0]      an_n_reg, an_n_next;
    logic [3:0]      nibble_reg, nibble_next;
    logic            fs_reg, fs_next;

    logic [3:0]      en_load;
    logic [3:0]      keep;
    logic [3:0]      slot_nib [4];
    logic [3:0]      slot_an  [4];

    // Per-slot decoder nibble and anode pattern taken from the frame's shadow copy.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_slot
            assign slot_nib[gi] = val_sh_reg[4*gi +: 4];
            assign slot_an[gi]  = en_sh_reg[gi] ? ~(4'b0001 << gi) : 4'b1111;
`ifdef SEG7_LZB_EN
            // A digit stays enabled only if it or a more significant digit is nonzero.
            if (gi == 0) begin : g_lsd
                assign keep[gi] = 1'b1;
            end else begin : g_upper
                assign keep[gi] = |bus.value[15:4*gi];
            end
`else
            assign keep[gi] = 1'b1;
`endif
        end
    endgenerate

    assign en_load = bus.digit_en & keep;

    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        presc_next  = presc_reg;
        val_sh_next = val_sh_reg;
        en_sh_next  = en_sh_reg;
        an_n_next   = 4'b1111;
        nibble_next = nibble_reg;
        fs_next     = 1'b0;
        case (state_reg)
            LOAD: begin
                val_sh_next = bus.value;
                en_sh_next  = en_load;
                fs_next     = 1'b1;
                nibble_next = bus.value[3:0];
                idx_next    = 2'd0;
                presc_next  = '0;
                state_next  = SCAN;
            end
            SCAN: begin
                an_n_next   = slot_an[idx_reg];
                nibble_next = slot_nib[idx_reg];
                if (presc_reg == TICK) begin
                    presc_next = '0;
                    if (idx_reg == 2'd3) begin
                        state_next = LOAD;
                    end else begin
                        idx_next   = idx_reg + 2'd1;
                        state_next = GUARD;
                    end
                end else begin
                    presc_next = presc_reg + CW'(1);
                end
            end
            GUARD: begin
                // Dark cycle between digits; the next nibble is presented early.
                nibble_next = slot_nib[idx_reg];
                state_next  = SCAN;
            end
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= LOAD;
            idx_reg    <= 2'd0;
            presc_reg  <= '0;
            val_sh_reg <= '0;
            en_sh_reg  <= '0;
            an_n_reg   <= 4'b1111;
            nibble_reg <= 4'd0;
            fs_reg     <= 1'b0;
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            presc_reg  <= presc_next;
            val_sh_reg <= val_sh_next;
            en_sh_reg  <= en_sh_next;
            an_n_reg   <= an_n_next;
            nibble_reg <= nibble_next;
            fs_reg     <= fs_next;
        end
    end

    assign bus.an_n        = an_n_reg;
    assign bus.nibble      = nibble_reg;
    assign bus.frame_start = fs_reg;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Randomized bench for seg7_scan_ctrl: two instances (SCAN_DIV=4 and SCAN_DIV=1)
// checked every cycle against a frame-phase model, plus literal first-frame patterns.
module tb_seg7_scan_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic check_en = 1'b0;
    int tests = 0;
    int fails = 0;

    seg7_scan_ctrl_if bus_a ();
    seg7_scan_ctrl_if bus_b ();

    seg7_scan_ctrl #(.SCAN_DIV(4)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    seg7_scan_ctrl #(.SCAN_DIV(1)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    always #5 clk = ~clk;

    logic [15:0] value;
    logic [3:0]  digit_en;
    assign bus_a.value = value;
    assign bus_a.digit_en = digit_en;
    assign bus_b.value = value;
    assign bus_b.digit_en = digit_en;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Enable mask loaded at frame start.
    function automatic logic [3:0] frame_en(input logic [15:0] v, input logic [3:0] en);
        logic [3:0] m;
        m = 4'b0001;
`ifdef SEG7_LZB_EN
        for (int d = 1; d < 4; d++)
            if (v[15:4*d] != 0) m[d] = 1'b1;
`else
        m = 4'b1111;
`endif
        return en & m;
    endfunction

    // Outputs at phase ph (1..4*(d+1)-1) of a frame: d lit cycles per slot, one dark between slots.
    function automatic logic [7:0] scan_out(input int ph, input int d,
                                            input logic [15:0] sv, input logic [3:0] se);
        int q, slot, r;
        logic [3:0] an;
        q = ph - 1;
        slot = q / (d + 1);
        r = q % (d + 1);
        if (r < d) begin
            an = se[slot] ? ~(4'b0001 << slot) : 4'b1111;
            return {an, sv[slot*4 +: 4]};
        end
        return {4'b1111, sv[(slot+1)*4 +: 4]};
    endfunction

    // Reference model, one per instance.
    logic [3:0] ea_an, ea_nib, eb_an, eb_nib;
    logic ea_fs, eb_fs;
    logic [15:0] sva, svb;
    logic [3:0] sea, seb;
    int pha, phb;

    always @(posedge clk) begin
        if (reset) begin
            ea_an <= 4'hF; ea_nib <= 4'h0; ea_fs <= 1'b0; pha <= 0;
            eb_an <= 4'hF; eb_nib <= 4'h0; eb_fs <= 1'b0; phb <= 0;
        end else begin
            if (pha == 0) begin
                sva <= value; sea <= frame_en(value, digit_en);
                ea_an <= 4'hF; ea_nib <= value[3:0]; ea_fs <= 1'b1;
            end else begin
                {ea_an, ea_nib} <= scan_out(pha, 4, sva, sea); ea_fs <= 1'b0;
            end
            pha <= (pha + 1) % 20;
            if (phb == 0) begin
                svb <= value; seb <= frame_en(value, digit_en);
                eb_an <= 4'hF; eb_nib <= value[3:0]; eb_fs <= 1'b1;
            end else begin
                {eb_an, eb_nib} <= scan_out(phb, 1, svb, seb); eb_fs <= 1'b0;
            end
            phb <= (phb + 1) % 8;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("a_an_n", int'(bus_a.an_n), int'(ea_an));
            chk("a_nibble", int'(bus_a.nibble), int'(ea_nib));
            chk("a_frame_start", int'(bus_a.frame_start), int'(ea_fs));
            chk("b_an_n", int'(bus_b.an_n), int'(eb_an));
            chk("b_nibble", int'(bus_b.nibble), int'(eb_nib));
            chk("b_frame_start", int'(bus_b.frame_start), int'(eb_fs));
            chk("a_onehot", int'($countones(~bus_a.an_n) <= 1), 1);
        end
    end

    logic [3:0] lit_an_a [21] = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD, 4'hD,
                                  4'hF, 4'hB, 4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7, 4'h7, 4'hF};
    logic [3:0] lit_nib_a [21] = '{4, 4, 4, 4, 4, 3, 3, 3, 3, 3, 2, 2, 2, 2, 2, 1, 1, 1, 1, 1, 4};
    logic [3:0] lit_an_b [9] = '{4'hF, 4'hE, 4'hF, 4'hD, 4'hF, 4'hB, 4'hF, 4'h7, 4'hF};
    logic [3:0] lit_nib_b [9] = '{4, 4, 3, 3, 2, 2, 1, 1, 4};

    task automatic run_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        value = 16'h1234;
        digit_en = 4'hF;
        reset = 1'b1;
        @(negedge clk);
        check_en = 1'b1;
        chk("reset_an_n", int'(bus_a.an_n), 15);
        chk("reset_frame_start", int'(bus_a.frame_start), 0);
        run_cycles(1);
        reset = 1'b0;
        // Hand-computed first frame for value 1234, all digits enabled.
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            chk("lit_a_an_n", int'(bus_a.an_n), int'(lit_an_a[i]));
            chk("lit_a_nibble", int'(bus_a.nibble), int'(lit_nib_a[i]));
            chk("lit_a_fs", int'(bus_a.frame_start), (i == 0 || i == 20) ? 1 : 0);
            if (i < 9) begin
                chk("lit_b_an_n", int'(bus_b.an_n), int'(lit_an_b[i]));
                chk("lit_b_nibble", int'(bus_b.nibble), int'(lit_nib_b[i]));
            end
        end
        // Mid-frame value change, sparse enables, leading zeros, zero value.
        run_cycles(7);
        value = 16'hABCD;
        run_cycles(30);
        digit_en = 4'b0101;
        run_cycles(40);
        digit_en = 4'hF;
        value = 16'h0070;
        run_cycles(40);
        value = 16'h0000;
        run_cycles(40);
        // Reset in the middle of a frame.
        value = 16'h5678;
        run_cycles(13);
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_an_n", int'(bus_a.an_n), 15);
        chk("midreset_fs", int'(bus_a.frame_start), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_load", int'(bus_a.frame_start), 1);
        @(negedge clk);
        chk("post_reset_slot0", int'(bus_a.an_n), 14);
        // Randomized traffic with occasional resets.
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 9) == 0) begin
                value = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 3)));
                digit_en = 4'($urandom);
            end
            reset = ($urandom_range(0, 199) == 0);
            @(negedge clk);
        end
        reset = 1'b0;
        run_cycles(5);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
